// File: rtl/rf_rd_arb_if.sv
// -----------------------------------------------------------------------------
// rf_rd_arb_if
// Purpose : bundles every decode, execute, debug and register-file signal of
//           the operand read arbiter. Names keep the arbiter's point of view:
//           *_i are inputs to the arbiter and *_o are outputs from it.
// Modports: slave  - the arbiter (rf_rd_arb)
//           master - the surroundings (decoder, execute, debug, register file)
// Signals : id_valid_i/id_ready_o, rs1/rs2_req_i, rs1/rs2_addr_i  decode side
//           op_valid_o/ex_ready_i, rs1/rs2_data_o, flush_i        execute side
//           dbg_req_i/dbg_addr_i/dbg_gnt_o/dbg_rvalid_o/dbg_rdata_o debug
//           rf_re_o/rf_raddr_o/rf_rdata_i                         RF port
//           wb_we_i/wb_waddr_i/wb_wdata_i  only with RF_RD_ARB_BYPASS_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface rf_rd_arb_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  id_valid_i;
  logic                  id_ready_o;
  logic                  rs1_req_i;
  logic                  rs2_req_i;
  logic [REG_ADDR_W-1:0] rs1_addr_i;
  logic [REG_ADDR_W-1:0] rs2_addr_i;
  logic                  op_valid_o;
  logic                  ex_ready_i;
  logic [DATA_W-1:0]     rs1_data_o;
  logic [DATA_W-1:0]     rs2_data_o;
  logic                  flush_i;
  logic                  dbg_req_i;
  logic [REG_ADDR_W-1:0] dbg_addr_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [DATA_W-1:0]     dbg_rdata_o;
  logic                  rf_re_o;
  logic [REG_ADDR_W-1:0] rf_raddr_o;
  logic [DATA_W-1:0]     rf_rdata_i;
`ifdef RF_RD_ARB_BYPASS_EN
  logic                  wb_we_i;
  logic [REG_ADDR_W-1:0] wb_waddr_i;
  logic [DATA_W-1:0]     wb_wdata_i;
`endif

  modport slave (
    input  id_valid_i, rs1_req_i, rs2_req_i, rs1_addr_i, rs2_addr_i,
    input  ex_ready_i, flush_i, dbg_req_i, dbg_addr_i, rf_rdata_i,
`ifdef RF_RD_ARB_BYPASS_EN
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
`endif
    output id_ready_o, op_valid_o, rs1_data_o, rs2_data_o,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, rf_re_o, rf_raddr_o
  );

  modport master (
    output id_valid_i, rs1_req_i, rs2_req_i, rs1_addr_i, rs2_addr_i,
    output ex_ready_i, flush_i, dbg_req_i, dbg_addr_i, rf_rdata_i,
`ifdef RF_RD_ARB_BYPASS_EN
    output wb_we_i, wb_waddr_i, wb_wdata_i,
`endif
    input  id_ready_o, op_valid_o, rs1_data_o, rs2_data_o,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, rf_re_o, rf_raddr_o
  );
endinterface

// File: rtl/rf_rd_arb.sv
// -----------------------------------------------------------------------------
// rf_rd_arb
// Purpose : sequences the rs1/rs2 operand reads of the decode stage through a
//           single register-file read port, hands the operand bundle to execute
//           with valid/ready, and slips debug reads into idle gaps. A debug
//           request denied DBG_MAX_WAIT cycles in a row wins the next IDLE slot.
// Ports   : clk            rising-edge clock
//           rst_n          synchronous reset, asserted when rst_n == `RstEnable
//           bus (slave)    decode / execute / debug / register-file signals
// Macro   : RF_RD_ARB_BYPASS_EN - adds write-back forwarding into captures and
//           into the held operand bundle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef RstEnable
`define RstEnable 1'b1
`endif

module rf_rd_arb #(
  parameter int REG_ADDR_W   = 5,
  parameter int DATA_W       = 32,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rf_rd_arb_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_CAP  = 3'd3,
    ST_VLD  = 3'd4,
    ST_DBG  = 3'd5,
    ST_DBGC = 3'd6
  } state_t;

  // Destination of the data returned one cycle after a read enable.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RS1  = 2'd1,
    TAG_RS2  = 2'd2,
    TAG_DBG  = 2'd3
  } tag_t;

  localparam logic [7:0]            MAX_WAIT = 8'(DBG_MAX_WAIT);
  localparam logic [REG_ADDR_W-1:0] ADDR_X0  = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]     DATA_0   = {DATA_W{1'b0}};

  state_t                r_state;
  state_t                w_state_nxt;
  tag_t                  r_tag;
  tag_t                  w_tag_nxt;
  logic [7:0]            r_cnt;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [REG_ADDR_W-1:0] r_dbg_addr;
  logic                  r_need2;
  logic [DATA_W-1:0]     r_rs1_data;
  logic [DATA_W-1:0]     r_rs2_data;
  logic [DATA_W-1:0]     r_dbg_rdata;
  logic                  r_dbg_rvalid;

  logic                  w_rst;
  logic                  w_need1_in;
  logic                  w_need2_in;
  logic                  w_dbg_force;
  logic                  w_id_ready;
  logic                  w_dbg_gnt;
  logic                  w_accept;
  logic                  w_flush_op;
  logic                  w_rf_re;
  logic [REG_ADDR_W-1:0] w_rf_raddr;
  logic [DATA_W-1:0]     w_cap_data;

`ifdef RF_RD_ARB_BYPASS_EN
  logic                  r_need1;
  logic [REG_ADDR_W-1:0] w_cap_addr;
`endif

  assign w_rst       = (rst_n == `RstEnable);
  assign w_need1_in  = bus.rs1_req_i && (bus.rs1_addr_i != ADDR_X0);
  assign w_need2_in  = bus.rs2_req_i && (bus.rs2_addr_i != ADDR_X0);
  assign w_dbg_force = bus.dbg_req_i && (r_cnt == MAX_WAIT);
  // Ready/grant are held low while reset is asserted so every output reads 0.
  assign w_id_ready  = (r_state == ST_IDLE) && !w_dbg_force && !bus.flush_i && !w_rst;
  assign w_dbg_gnt   = (r_state == ST_IDLE) && bus.dbg_req_i &&
                       (w_dbg_force || !bus.id_valid_i) && !w_rst;
  assign w_accept    = bus.id_valid_i && w_id_ready;
  // Flush only aborts the decode-side states; debug reads always complete.
  assign w_flush_op  = bus.flush_i &&
                       ((r_state == ST_RD1) || (r_state == ST_RD2) ||
                        (r_state == ST_CAP) || (r_state == ST_VLD));

  // Next-state, read-port decode and capture-tag selection.
  always_comb begin
    w_state_nxt = r_state;
    w_rf_re     = 1'b0;
    w_rf_raddr  = ADDR_X0;
    w_tag_nxt   = TAG_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_dbg_gnt) begin
          w_state_nxt = ST_DBG;
        end else if (w_accept) begin
          if (w_need1_in) begin
            w_state_nxt = ST_RD1;
          end else if (w_need2_in) begin
            w_state_nxt = ST_RD2;
          end else begin
            w_state_nxt = ST_VLD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD1: begin
        w_rf_re    = 1'b1;
        w_rf_raddr = r_rs1_addr;
        w_tag_nxt  = TAG_RS1;
        w_state_nxt = r_need2 ? ST_RD2 : ST_CAP;
      end
      ST_RD2: begin
        w_rf_re     = 1'b1;
        w_rf_raddr  = r_rs2_addr;
        w_tag_nxt   = TAG_RS2;
        w_state_nxt = ST_CAP;
      end
      ST_CAP: begin
        w_state_nxt = ST_VLD;
      end
      ST_VLD: begin
        if (bus.ex_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_VLD;
        end
      end
      ST_DBG: begin
        w_rf_re     = 1'b1;
        w_rf_raddr  = r_dbg_addr;
        w_tag_nxt   = TAG_DBG;
        w_state_nxt = ST_DBGC;
      end
      ST_DBGC: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // A flushed read issued this cycle must not be captured next cycle.
    if (w_flush_op) begin
      w_state_nxt = ST_IDLE;
      w_tag_nxt   = TAG_NONE;
    end else begin
      w_tag_nxt   = w_tag_nxt;
    end
  end

`ifdef RF_RD_ARB_BYPASS_EN
  // Address belonging to the data being captured, for write-back matching.
  always_comb begin
    case (r_tag)
      TAG_RS1: w_cap_addr = r_rs1_addr;
      TAG_RS2: w_cap_addr = r_rs2_addr;
      TAG_DBG: w_cap_addr = r_dbg_addr;
      default: w_cap_addr = ADDR_X0;
    endcase
  end

  // Capture source: a same-cycle write-back to the same register wins.
  always_comb begin
    if (bus.wb_we_i && (bus.wb_waddr_i == w_cap_addr) && (w_cap_addr != ADDR_X0)) begin
      w_cap_data = bus.wb_wdata_i;
    end else begin
      w_cap_data = bus.rf_rdata_i;
    end
  end
`else
  assign w_cap_data = bus.rf_rdata_i;
`endif

  // State and capture-tag registers.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_tag   <= TAG_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

  // Debug starvation counter, saturating at DBG_MAX_WAIT.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_cnt <= 8'd0;
    end else if (w_dbg_gnt || !bus.dbg_req_i) begin
      r_cnt <= 8'd0;
    end else if (r_cnt != MAX_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Address latches, operand/debug data capture and the debug valid pulse.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rs1_addr   <= ADDR_X0;
      r_rs2_addr   <= ADDR_X0;
      r_dbg_addr   <= ADDR_X0;
      r_need2      <= 1'b0;
      r_rs1_data   <= DATA_0;
      r_rs2_data   <= DATA_0;
      r_dbg_rdata  <= DATA_0;
      r_dbg_rvalid <= 1'b0;
`ifdef RF_RD_ARB_BYPASS_EN
      r_need1      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_rs1_addr <= bus.rs1_addr_i;
        r_rs2_addr <= bus.rs2_addr_i;
        r_need2    <= w_need2_in;
        // Unneeded operands must read as zero, so start each bundle cleared.
        r_rs1_data <= DATA_0;
        r_rs2_data <= DATA_0;
`ifdef RF_RD_ARB_BYPASS_EN
        r_need1    <= w_need1_in;
`endif
      end else if (!w_flush_op) begin
        case (r_tag)
          TAG_RS1: r_rs1_data  <= w_cap_data;
          TAG_RS2: r_rs2_data  <= w_cap_data;
          TAG_DBG: r_dbg_rdata <= w_cap_data;
          default: r_dbg_rdata <= r_dbg_rdata;
        endcase
`ifdef RF_RD_ARB_BYPASS_EN
        // Keep a held bundle coherent with later write-backs.
        if ((r_state == ST_VLD) && bus.wb_we_i && (bus.wb_waddr_i != ADDR_X0)) begin
          if (r_need1 && (bus.wb_waddr_i == r_rs1_addr)) begin
            r_rs1_data <= bus.wb_wdata_i;
          end
          if (r_need2 && (bus.wb_waddr_i == r_rs2_addr)) begin
            r_rs2_data <= bus.wb_wdata_i;
          end
        end
`endif
      end
      if (w_dbg_gnt) begin
        r_dbg_addr <= bus.dbg_addr_i;
      end
      r_dbg_rvalid <= (r_state == ST_DBGC);
    end
  end

  assign bus.id_ready_o   = w_id_ready;
  assign bus.dbg_gnt_o    = w_dbg_gnt;
  assign bus.op_valid_o   = (r_state == ST_VLD);
  assign bus.rs1_data_o   = r_rs1_data;
  assign bus.rs2_data_o   = r_rs2_data;
  assign bus.dbg_rvalid_o = r_dbg_rvalid;
  assign bus.dbg_rdata_o  = r_dbg_rdata;
  assign bus.rf_re_o      = w_rf_re;
  assign bus.rf_raddr_o   = w_rf_raddr;

endmodule

// File: doc/rf_rd_arb.md
Name: rf_rd_arb

Overview:
- Sequences register-file operand reads for the decode stage and shares the single register-file read port between decode (rs1/rs2) and a debug read requester.
- Sits between the decoder and the register file, and hands an operand bundle to execute with a valid/ready handshake.
- Reads of x0 are skipped.
- Debug reads are serviced in idle gaps, with a starvation bound.

Parameters:
REG_ADDR_W, 5, register address width
DATA_W, 32, register data width
DBG_MAX_WAIT, 8, consecutive denied debug-request cycles before debug gets priority (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous, active-high reset (asserted when rst_n == `RstEnable, `RstEnable = 1'b1)
id_valid_i  in  1  decoded instruction presents operand addresses
id_ready_o  out  1  arbiter accepts a decode request this cycle
rs1_req_i / rs2_req_i  in  1 each  operand needed (from decoder read-valid flags)
rs1_addr_i / rs2_addr_i  in  REG_ADDR_W each  operand addresses
op_valid_o  out  1  operand bundle valid
ex_ready_i  in  1  execute consumes bundle
rs1_data_o / rs2_data_o  out  DATA_W each  operand data
flush_i  in  1  abort decode-side transaction
dbg_req_i  in  1  debug read request, held until granted
dbg_addr_i  in  REG_ADDR_W  debug read address
dbg_gnt_o  out  1  debug request accepted (single cycle)
dbg_rvalid_o  out  1  debug data valid (single cycle)
dbg_rdata_o  out  DATA_W  debug read data
rf_re_o  out  1  register-file read enable
rf_raddr_o  out  REG_ADDR_W  register-file read address
rf_rdata_i  in  DATA_W  register-file data, valid the cycle after rf_re_o

Behaviour:
- Reset: state = IDLE; all outputs and data/address latches are 0; the starvation counter is 0.
- States:
  - IDLE
  - RD1: drive rs1
  - RD2: drive rs2
  - CAP: capture last data
  - VLD: op_valid_o = 1
  - DBG: drive the debug address
  - DBGC: capture the debug data
- rf_re_o and rf_raddr_o are decoded from the state and latched addresses only; there is no combinational path from any input to them.
- Operand need: rsN needed = rsN_req_i && rsN_addr_i != 0. An unneeded operand's data is 0.
- IDLE grant rules:
  - dbg_force = dbg_req_i && cnt == DBG_MAX_WAIT.
  - id_ready_o = (state == IDLE) && !dbg_force.
  - dbg_gnt_o = (state == IDLE) && dbg_req_i && (dbg_force || !id_valid_i).
- Accept (id_valid_i && id_ready_o) latches the addresses and need flags. Next state:
  - RD1 if rs1 is needed;
  - else RD2 if rs2 is needed;
  - else VLD.
- Data capture: a registered tag records the target (RS1/RS2/DBG) of each rf_re_o. rf_rdata_i is written into that target on the following cycle.
- RD1 -> RD2 if rs2 is needed, else CAP. RD2 -> CAP. CAP -> VLD.
- Latency from the accept edge to op_valid_o:
  - 4 cycles with both operands;
  - 3 cycles with one operand;
  - 1 cycle with none.
- VLD: op_valid_o and the data are held stable until ex_ready_i. On ex_ready_i the state returns to IDLE, so there is at most 1 accept per transaction and at least one IDLE cycle between bundles.
- Debug path:
  - dbg_gnt_o latches dbg_addr_i; the state goes DBG (rf_re_o = 1), then DBGC (capture).
  - The next cycle is IDLE with dbg_rvalid_o = 1 for one cycle.
  - dbg_rdata_o holds its value until the next debug capture.
  - Address 0 is read through the port.
- Starvation counter:
  - Increments (saturating at DBG_MAX_WAIT) each cycle dbg_req_i = 1 && dbg_gnt_o = 0.
  - Clears on dbg_gnt_o or when dbg_req_i = 0.
- flush_i:
  - In RD1/RD2/CAP/VLD, the state goes to IDLE next cycle and op_valid_o = 0.
  - Any in-flight rs capture is discarded (tag cleared).
  - In IDLE, flush_i blocks an accept that cycle (id_ready_o forced 0).
  - flush_i has no effect on DBG/DBGC.
- Reset mid-operation: all state, the tag, the counter and the outputs return to reset values on the next edge; any in-flight read is dropped.

Optional Feature:
RF_RD_ARB_BYPASS_EN
- Defined:
  - Adds ports wb_we_i (1), wb_waddr_i (REG_ADDR_W) and wb_wdata_i (DATA_W).
  - On every capture cycle, if wb_we_i && wb_waddr_i == captured address && address != 0, wb_wdata_i is stored instead of rf_rdata_i.
  - In VLD, a matching write-back also updates the held operand.
- Undefined: the ports are absent; only rf_rdata_i is captured.

Test Plan:
- Reset: rst_n = 1 for 2 cycles mid-RD2 -> all outputs 0, state IDLE, and no op_valid_o within 5 cycles of release without a new request.
- Two operands: accept rs1 = 3, rs2 = 7, with rf returning 0x11/0x22 -> rf_raddr_o 3 then 7 on consecutive cycles; op_valid_o 4 cycles after accept with rs1_data_o = 0x11 and rs2_data_o = 0x22; held while ex_ready_i = 0 for 3 cycles.
- x0 skip: rs1_addr = 0 with rs2 needed -> one rf_re_o only; rs1_data_o = 0; latency 3. Both operands unneeded -> op_valid_o after 1 cycle with no rf_re_o.
- Debug starvation: continuous id_valid_i plus dbg_req_i with DBG_MAX_WAIT = 8 -> dbg_gnt_o on the IDLE cycle after the counter reaches 8 and id_ready_o = 0 that cycle; dbg_rvalid_o 3 cycles after grant with the correct data.
- Flush: flush_i in RD2 -> next cycle IDLE, no op_valid_o; late rf_rdata_i does not alter rs1_data_o or rs2_data_o. flush_i in DBG -> debug completes normally.
- Bypass (RF_RD_ARB_BYPASS_EN): wb_we_i with wb_waddr_i = 7 and wb_wdata_i = 0x55 during the rs2 capture cycle -> rs2_data_o = 0x55. With wb_waddr_i = 0 -> rf data is used.
